// File: rtl/timing_pkg.sv
// ---------------------------------------------------------------------------
// timing_pkg
// Shared definitions for the timing sweep sequencer:
//   - state_t   : sequencer state encoding
//   - DEF_*     : default parameter values (candidate range, sample count,
//                 measurement counter width)
//   - clog2()   : constant function used to size the latency accumulator
// ---------------------------------------------------------------------------
package timing_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_MEAS,
    ST_GAP,
    ST_NEXT,
    ST_FIN
  } state_t;

  localparam logic [7:0] DEF_CAND_FIRST = 8'h20;
  localparam logic [7:0] DEF_CAND_LAST  = 8'h7E;
  localparam int         DEF_SAMPLES    = 4;
  localparam int         DEF_CNT_W      = 24;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/timing_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// timing_sweep_ctrl_if
// Target-side handshake between the sweep sequencer and the UART
// transmitter / trigger pair.
//   tx_data    : byte to transmit (sequencer -> UART)
//   tx_start   : one-cycle transmit request (sequencer -> UART)
//   tx_busy    : transmitter busy (UART -> sequencer)
//   trig_en    : one-cycle arm pulse (sequencer -> trigger)
//   trig_valid : detection pulse (trigger -> sequencer)
// Modports: master = sequencer side, slave = UART/trigger side.
// ---------------------------------------------------------------------------
interface timing_sweep_ctrl_if;

  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       trig_en;
  logic       trig_valid;

  modport master (
    output tx_data,
    output tx_start,
    output trig_en,
    input  tx_busy,
    input  trig_valid
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    input  trig_en,
    output tx_busy,
    output trig_valid
  );

endinterface

// File: rtl/lat_counter.sv
// ---------------------------------------------------------------------------
// lat_counter
// Per-measurement cycle counter with synchronous clear and count enable.
// The count saturates at all-ones so it can never wrap back below the
// timeout threshold.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_clear     : force count to zero (has priority over i_en)
//   i_en        : increment by one
//   o_cnt       : current count
//   o_at_limit  : count equals LIMIT
// ---------------------------------------------------------------------------
module lat_counter
  import timing_pkg::*;
#(
  parameter int           W     = DEF_CNT_W,
  parameter logic [W-1:0] LIMIT = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_at_limit
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt      = r_cnt;
  assign o_at_limit = (r_cnt == LIMIT);

endmodule

// File: rtl/timing_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// timing_sweep_ctrl
// Walks candidate bytes CAND_FIRST..CAND_LAST. For each candidate it sends
// the byte through the UART and arms the trigger in the same cycle, counts
// cycles until trig_valid, and sums SAMPLES such latencies. The candidate
// with the strictly largest sum wins (ties keep the earlier candidate).
// A measurement that reaches TIMEOUT without trig_valid aborts the sweep.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_start        : one-cycle sweep request, ignored while busy
//   o_busy         : sweep in progress (through the done cycle)
//   o_done         : one-cycle end-of-sweep pulse
//   o_best_char    : winning candidate
//   o_best_time    : accumulated latency of the winner
//   o_timeout_err  : sweep aborted on timeout
//   bus            : UART/trigger handshake (timing_sweep_ctrl_if.master)
//
// Optional feature, macro TIMING_SWEEP_RESULT_STREAM_EN:
//   o_res_valid/o_res_char/o_res_time pulse during every NEXT state with
//   that candidate's total. Absent when the macro is undefined.
// ---------------------------------------------------------------------------
module timing_sweep_ctrl
  import timing_pkg::*;
#(
  parameter logic [7:0]       CAND_FIRST = DEF_CAND_FIRST,
  parameter logic [7:0]       CAND_LAST  = DEF_CAND_LAST,
  parameter int               SAMPLES    = DEF_SAMPLES,
  parameter int               CNT_W      = DEF_CNT_W,
  parameter logic [CNT_W-1:0] TIMEOUT    = {CNT_W{1'b1}},
  localparam int              ACC_W      = CNT_W + clog2(SAMPLES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  output logic [7:0]          o_best_char,
  output logic [ACC_W-1:0]    o_best_time,
  output logic                o_timeout_err,
  timing_sweep_ctrl_if.master bus
`ifdef TIMING_SWEEP_RESULT_STREAM_EN
  ,
  output logic                o_res_valid,
  output logic [7:0]          o_res_char,
  output logic [ACC_W-1:0]    o_res_time
`endif
);

  localparam int SMP_W  = clog2(SAMPLES);
  localparam int SIDX_W = (SMP_W > 0) ? SMP_W : 1;
  localparam logic [SIDX_W-1:0] LAST_SAMPLE = SIDX_W'(SAMPLES - 1);

  state_t              r_state, w_state_next;
  logic [7:0]          r_cand, w_cand_next;
  logic [SIDX_W-1:0]   r_sample, w_sample_next;
  logic [ACC_W-1:0]    r_acc, w_acc_next;
  logic [7:0]          r_best_char, w_best_char_next;
  logic [ACC_W-1:0]    r_best_time, w_best_time_next;
  logic                r_timeout_err, w_timeout_err_next;

  logic                w_cnt_clear;
  logic                w_cnt_en;
  logic                w_at_limit;
  logic [CNT_W-1:0]    w_cnt;
  logic [CNT_W:0]      w_lat;
  logic [ACC_W:0]      w_sum;
  logic [ACC_W-1:0]    w_acc_add;

  logic                w_tx_start;
  logic                w_trig_en;
  logic                w_done;

  lat_counter #(
    .W     (CNT_W),
    .LIMIT (TIMEOUT)
  ) u_lat_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_cnt_clear),
    .i_en       (w_cnt_en),
    .o_cnt      (w_cnt),
    .o_at_limit (w_at_limit)
  );

  // The counter reads 0 in the first cycle after the arm pulse, so the
  // latency is cnt+1. One extra bit on each sum covers the corner where the
  // answer lands exactly at an all-ones TIMEOUT; the sum then saturates.
  assign w_lat     = {1'b0, w_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_sum     = {1'b0, r_acc} + (ACC_W+1)'(w_lat);
  assign w_acc_add = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

  // Next-state and control outputs.
  always_comb begin
    w_state_next       = r_state;
    w_cand_next        = r_cand;
    w_sample_next      = r_sample;
    w_acc_next         = r_acc;
    w_best_char_next   = r_best_char;
    w_best_time_next   = r_best_time;
    w_timeout_err_next = r_timeout_err;
    w_tx_start         = 1'b0;
    w_trig_en          = 1'b0;
    w_done             = 1'b0;
    w_cnt_clear        = 1'b0;
    w_cnt_en           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next       = ST_SEND;
          w_cand_next        = CAND_FIRST;
          w_sample_next      = '0;
          w_acc_next         = '0;
          w_best_char_next   = CAND_FIRST;
          w_best_time_next   = '0;
          w_timeout_err_next = 1'b0;
        end
      end

      ST_SEND: begin
        // Transmit and arm together so the measured latency starts at the
        // moment the byte leaves.
        if (!bus.tx_busy) begin
          w_tx_start   = 1'b1;
          w_trig_en    = 1'b1;
          w_cnt_clear  = 1'b1;
          w_state_next = ST_MEAS;
        end
      end

      ST_MEAS: begin
        w_cnt_en = 1'b1;
        // A detection in the same cycle as the limit still counts.
        if (bus.trig_valid) begin
          w_acc_next   = w_acc_add;
          w_state_next = ST_GAP;
        end else if (w_at_limit) begin
          w_timeout_err_next = 1'b1;
          w_state_next       = ST_FIN;
        end
      end

      ST_GAP: begin
        if (!bus.tx_busy) begin
          if (r_sample < LAST_SAMPLE) begin
            w_sample_next = r_sample + 1'b1;
            w_state_next  = ST_SEND;
          end else begin
            w_state_next = ST_NEXT;
          end
        end
      end

      ST_NEXT: begin
        if (r_acc > r_best_time) begin
          w_best_char_next = r_cand;
          w_best_time_next = r_acc;
        end
        if (r_cand == CAND_LAST) begin
          w_state_next = ST_FIN;
        end else begin
          w_cand_next   = r_cand + 8'd1;
          w_sample_next = '0;
          w_acc_next    = '0;
          w_state_next  = ST_SEND;
        end
      end

      ST_FIN: begin
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cand        <= CAND_FIRST;
      r_sample      <= '0;
      r_acc         <= '0;
      r_best_char   <= 8'h00;
      r_best_time   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cand        <= w_cand_next;
      r_sample      <= w_sample_next;
      r_acc         <= w_acc_next;
      r_best_char   <= w_best_char_next;
      r_best_time   <= w_best_time_next;
      r_timeout_err <= w_timeout_err_next;
    end
  end

`ifdef TIMING_SWEEP_RESULT_STREAM_EN
  // Loaded on the GAP->NEXT transition so the pulse lines up with NEXT.
  logic             r_res_valid;
  logic [7:0]       r_res_char;
  logic [ACC_W-1:0] r_res_time;
  logic             w_res_load;

  assign w_res_load = (r_state == ST_GAP) && (w_state_next == ST_NEXT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_char  <= 8'h00;
      r_res_time  <= '0;
    end else begin
      r_res_valid <= w_res_load;
      if (w_res_load) begin
        r_res_char <= r_cand;
        r_res_time <= r_acc;
      end
    end
  end

  assign o_res_valid = r_res_valid;
  assign o_res_char  = r_res_char;
  assign o_res_time  = r_res_time;
`endif

  // tx_data is only driven while a send is pending so it reads 0 otherwise.
  assign bus.tx_data    = (r_state == ST_SEND) ? r_cand : 8'h00;
  assign bus.tx_start   = w_tx_start;
  assign bus.trig_en    = w_trig_en;

  assign o_busy         = (r_state != ST_IDLE);
  assign o_done         = w_done;
  assign o_best_char    = r_best_char;
  assign o_best_time    = r_best_time;
  assign o_timeout_err  = r_timeout_err;

endmodule
